// File: rtl/spiker_seq_pkg.sv
// Shared state encoding and sizing helpers for the spiker frame sequencer.
package spiker_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        ACCUM = 3'd4,
        DONE  = 3'd5
    } state_e;

    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_LOAD  = LOAD;
    localparam logic [2:0] ST_ISSUE = ISSUE;
    localparam logic [2:0] ST_WAIT  = WAIT;
    localparam logic [2:0] ST_ACCUM = ACCUM;
    localparam logic [2:0] ST_DONE  = DONE;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_N_SPIKES = 784;
    localparam int DEF_N_WORDS  = ceil_div(DEF_N_SPIKES, DEF_WIDTH);

endpackage

// File: rtl/spiker_count_bank.sv
// Per-neuron saturating spike counters; clear has priority over increment.
module spiker_count_bank
    import spiker_seq_pkg::*;
#(
    parameter int N_OUT = 10,
    parameter int CNT_W = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     inc_en_i,
    input  logic [N_OUT-1:0]         inc_i,
    output logic [N_OUT*CNT_W-1:0]   counts_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N_OUT*CNT_W-1:0] cnt_q;
    logic [N_OUT*CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_en_i) begin
            for (int j = 0; j < N_OUT; j++) begin
                if (inc_i[j] && (cnt_q[j*CNT_W +: CNT_W] != CNT_MAX)) begin
                    cnt_d[j*CNT_W +: CNT_W] = cnt_q[j*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign counts_o = cnt_q;

endmodule

// File: rtl/spiker_frame_sequencer.sv
// Snapshots a spike frame from register words, replays it to the spiking core for
// n_steps timesteps over valid/ready, and accumulates per-neuron output spike counts.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | copying one register word per cycle into the frame
// ISSUE | presenting the frame to the core until ready
// WAIT  | waiting for the core result, bounded by TIMEOUT
// ACCUM | adding the registered result into the counters
// DONE  | run finished (or timed out); counts held
module spiker_frame_sequencer
    import spiker_seq_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int N_SPIKES = DEF_N_SPIKES,
    parameter int N_OUT    = 10,
    parameter int CNT_W    = 8,
    parameter int STEP_W   = 8,
    parameter int TIMEOUT  = 1024,
    localparam int N_WORDS = ceil_div(N_SPIKES, WIDTH)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       clear_i,
    input  logic [STEP_W-1:0]          n_steps_i,
    input  logic [N_WORDS*WIDTH-1:0]   spikes_i,
    output logic [N_SPIKES-1:0]        core_data_o,
    output logic                       core_valid_o,
    input  logic                       core_ready_i,
    input  logic [N_OUT-1:0]           core_res_i,
    input  logic                       core_res_vld_i,
    output logic [N_OUT*CNT_W-1:0]     counts_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       error_o
);

    localparam int PAD_W  = N_WORDS * WIDTH;
    localparam int WORD_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(N_WORDS - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

    logic [2:0]        state_q,  state_d;
    logic [WORD_W-1:0] word_q,   word_d;
    logic [STEP_W-1:0] step_q,   step_d;
    logic [STEP_W-1:0] nsteps_q, nsteps_d;
    logic [TMO_W-1:0]  tmo_q,    tmo_d;
    logic [PAD_W-1:0]  pad_q,    pad_d;
    logic [N_OUT-1:0]  res_q,    res_d;
    logic              done_q,   done_d;
    logic              err_q,    err_d;
    logic              cnt_clr;
    logic              cnt_inc;
    int                base;

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        step_d   = step_q;
        nsteps_d = nsteps_q;
        tmo_d    = tmo_q;
        pad_d    = pad_q;
        res_d    = res_q;
        done_d   = done_q;
        err_d    = err_q;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        base     = int'(word_q) * WIDTH;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // start takes precedence over clear when both arrive together
                if (start_i) begin
                    nsteps_d = n_steps_i;
                    cnt_clr  = 1'b1;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    word_d   = '0;
                    step_d   = '0;
                    state_d  = ST_LOAD;
                end else if ((state_q == ST_DONE) && clear_i) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                pad_d[base +: WIDTH] = spikes_i[base +: WIDTH];
                if (word_q == LAST_WORD) begin
                    if (nsteps_q == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    word_d = word_q + WORD_W'(1);
                end
            end
            ST_ISSUE: begin
                if (core_ready_i) begin
                    tmo_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (core_res_vld_i) begin
                    res_d   = core_res_i;
                    state_d = ST_ACCUM;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_ACCUM: begin
                cnt_inc = 1'b1;
                step_d  = step_q + STEP_W'(1);
                if (step_d == nsteps_q) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            word_q   <= '0;
            step_q   <= '0;
            nsteps_q <= '0;
            tmo_q    <= '0;
            pad_q    <= '0;
            res_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            step_q   <= step_d;
            nsteps_q <= nsteps_d;
            tmo_q    <= tmo_d;
            pad_q    <= pad_d;
            res_q    <= res_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    spiker_count_bank #(
        .N_OUT (N_OUT),
        .CNT_W (CNT_W)
    ) u_count_bank (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (cnt_clr),
        .inc_en_i (cnt_inc),
        .inc_i    (res_q),
        .counts_o (counts_o)
    );

    // padding bits of the last word never reach the core
    assign core_data_o  = pad_q[N_SPIKES-1:0];
    assign core_valid_o = (state_q == ST_ISSUE);
    assign busy_o       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done_o       = done_q;
    assign error_o      = err_q;

endmodule

// File: tb/tb_spiker_frame_sequencer.sv
// Directed bench: a default-sized sequencer plus a small one (40 spikes, 2-bit counters, 16-cycle timeout).
module tb_spiker_frame_sequencer;

    logic clk;
    logic rst;

    logic         d_start, d_clear, d_ready, d_vld;
    logic [7:0]   d_steps;
    logic [799:0] d_spikes;
    logic [9:0]   d_res;
    logic [783:0] d_data;
    logic         d_valid, d_busy, d_done, d_err;
    logic [79:0]  d_counts;

    logic         s_start, s_clear, s_ready, s_vld;
    logic [7:0]   s_steps;
    logic [63:0]  s_spikes;
    logic [9:0]   s_res;
    logic [39:0]  s_data;
    logic         s_valid, s_busy, s_done, s_err;
    logic [19:0]  s_counts;

    int n_checks = 0;
    int n_fail   = 0;

    spiker_frame_sequencer u_def (
        .clk_i(clk), .rst_i(rst), .start_i(d_start), .clear_i(d_clear), .n_steps_i(d_steps),
        .spikes_i(d_spikes), .core_data_o(d_data), .core_valid_o(d_valid), .core_ready_i(d_ready),
        .core_res_i(d_res), .core_res_vld_i(d_vld), .counts_o(d_counts), .busy_o(d_busy),
        .done_o(d_done), .error_o(d_err)
    );

    spiker_frame_sequencer #(.WIDTH(32), .N_SPIKES(40), .CNT_W(2), .TIMEOUT(16)) u_small (
        .clk_i(clk), .rst_i(rst), .start_i(s_start), .clear_i(s_clear), .n_steps_i(s_steps),
        .spikes_i(s_spikes), .core_data_o(s_data), .core_valid_o(s_valid), .core_ready_i(s_ready),
        .core_res_i(s_res), .core_res_vld_i(s_vld), .counts_o(s_counts), .busy_o(s_busy),
        .done_o(s_done), .error_o(s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // Small-DUT core model: result pulse in the cycle after each handshake.
    task automatic s_drive_core(input int budget, output int hs, output bit fin);
        bit hs_now;
        hs  = 0;
        fin = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (s_done) begin
                fin = 1'b1;
                break;
            end
            hs_now = s_valid && s_ready;
            if (hs_now) hs++;
            @(posedge clk); #1;
            s_vld = hs_now;
        end
        s_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        d_start = 0; d_clear = 0; d_ready = 0; d_vld = 0; d_steps = '0; d_spikes = '0; d_res = '0;
        s_start = 0; s_clear = 0; s_ready = 0; s_vld = 0; s_steps = '0; s_spikes = '0; s_res = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL reset_d_valid: got %b want 0", d_valid); end
        n_checks++; if (d_busy !== 1'b0) begin n_fail++; $display("FAIL reset_d_busy: got %b want 0", d_busy); end
        n_checks++; if (d_done !== 1'b0) begin n_fail++; $display("FAIL reset_d_done: got %b want 0", d_done); end
        n_checks++; if (d_err !== 1'b0) begin n_fail++; $display("FAIL reset_d_err: got %b want 0", d_err); end
        n_checks++; if (d_data !== 784'd0) begin n_fail++; $display("FAIL reset_d_data: nonzero frame after reset"); end
        n_checks++; if (d_counts !== 80'd0) begin n_fail++; $display("FAIL reset_d_counts: got %h want 0", d_counts); end
        n_checks++; if ({s_valid, s_busy, s_done, s_err} !== 4'b0000) begin n_fail++; $display("FAIL reset_s_flags: got %b want 0000", {s_valid, s_busy, s_done, s_err}); end
        n_checks++; if ({s_data, s_counts} !== 60'd0) begin n_fail++; $display("FAIL reset_s_data_counts: got %h want 0", {s_data, s_counts}); end
    endtask

    task automatic test_default_run();
        int lat, hs, dly;
        bit hs_now, fin;
        d_spikes = '1; d_steps = 8'd3; d_ready = 1'b1; d_res = 10'h3FF; d_vld = 1'b0;
        @(posedge clk); #1 d_start = 1'b1;
        @(posedge clk); #1 d_start = 1'b0;
        lat = 1;
        while (lat < 100) begin
            @(negedge clk);
            if (d_valid) break;
            @(posedge clk);
            lat++;
        end
        n_checks++; if (lat !== 26) begin n_fail++; $display("FAIL default_first_valid: got start+%0d want start+26", lat); end
        hs = 0; dly = 0; fin = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (d_done) begin
                fin = 1'b1;
                break;
            end
            hs_now = d_valid && d_ready;
            if (hs_now) begin
                hs++;
                n_checks++; if (d_data !== {784{1'b1}}) begin n_fail++; $display("FAIL default_frame: handshake %0d frame not all ones", hs); end
            end
            @(posedge clk); #1;
            d_vld = (dly == 1);
            if (dly > 0) dly--;
            if (hs_now) dly = 2;
            @(negedge clk);
        end
        d_vld = 1'b0;
        n_checks++; if (fin !== 1'b1) begin n_fail++; $display("FAIL default_done: done not seen within cycle budget"); end
        n_checks++; if (hs !== 3) begin n_fail++; $display("FAIL default_handshakes: got %0d want 3", hs); end
        n_checks++; if (d_counts !== {10{8'd3}}) begin n_fail++; $display("FAIL default_counts: got %h want %h", d_counts, {10{8'd3}}); end
        n_checks++; if ({d_err, d_busy} !== 2'b00) begin n_fail++; $display("FAIL default_err_busy: got %b want 00", {d_err, d_busy}); end
    endtask

    task automatic test_frame_load();
        s_spikes = {32'hFFFF_FF00, 32'hA5A5_5A5A}; s_steps = 8'd0; s_ready = 1'b1; s_vld = 1'b0;
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        @(negedge clk);
        n_checks++; if ({s_busy, s_valid} !== 2'b10) begin n_fail++; $display("FAIL load_busy_valid: got %b want 10", {s_busy, s_valid}); end
        @(posedge clk); #1 s_spikes[31:0] = 32'h0;
        @(negedge clk);
        n_checks++; if ({s_valid, s_done} !== 2'b00) begin n_fail++; $display("FAIL load_mid: valid/done got %b want 00", {s_valid, s_done}); end
        @(posedge clk);
        @(negedge clk);
        n_checks++; if ({s_done, s_busy, s_valid, s_err} !== 4'b1000) begin n_fail++; $display("FAIL zero_steps_flags: done/busy/valid/err got %b want 1000", {s_done, s_busy, s_valid, s_err}); end
        n_checks++; if (s_data !== 40'h00_A5A5_5A5A) begin n_fail++; $display("FAIL load_frame: got %h want 00a5a55a5a", s_data); end
    endtask

    task automatic test_ready_stall();
        @(posedge clk); #1 s_clear = 1'b1;
        @(posedge clk); #1 s_clear = 1'b0;
        @(negedge clk);
        n_checks++; if ({s_done, s_err, s_busy} !== 3'b000) begin n_fail++; $display("FAIL clear_flags: done/err/busy got %b want 000", {s_done, s_err, s_busy}); end
        s_spikes = {32'h0000_0012, 32'h3456_789A}; s_steps = 8'd1; s_ready = 1'b0;
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if ({s_valid, s_data} !== {1'b1, 40'h12_3456_789A}) begin n_fail++; $display("FAIL stall_hold%0d: valid/data got %b/%h want 1/123456789a", i, s_valid, s_data); end
            @(posedge clk); #1;
            s_vld = (i == 1);
            s_res = 10'h3FF;
        end
        s_ready = 1'b1;
        @(posedge clk); #1;
        s_ready = 1'b0; s_res = 10'h005; s_vld = 1'b1;
        @(negedge clk);
        n_checks++; if ({s_valid, s_busy} !== 2'b01) begin n_fail++; $display("FAIL stall_wait: valid/busy got %b want 01", {s_valid, s_busy}); end
        @(posedge clk); #1 s_vld = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (s_done !== 1'b1) begin n_fail++; $display("FAIL stall_done: got %b want 1", s_done); end
        n_checks++; if (s_counts !== 20'h00011) begin n_fail++; $display("FAIL stall_counts: got %h want 00011", s_counts); end
    endtask

    task automatic test_saturate();
        int hs;
        bit fin;
        @(posedge clk); #1;
        s_start = 1'b1; s_clear = 1'b1; s_steps = 8'd6; s_res = 10'h001; s_ready = 1'b1;
        @(posedge clk); #1 s_start = 1'b0; s_clear = 1'b0;
        @(negedge clk);
        n_checks++; if ({s_busy, s_done} !== 2'b10) begin n_fail++; $display("FAIL start_beats_clear: busy/done got %b want 10", {s_busy, s_done}); end
        n_checks++; if (s_counts !== 20'h00000) begin n_fail++; $display("FAIL start_zeroes_counts: got %h want 00000", s_counts); end
        s_drive_core(200, hs, fin);
        n_checks++; if (fin !== 1'b1) begin n_fail++; $display("FAIL sat_done: done not seen within cycle budget"); end
        n_checks++; if (hs !== 6) begin n_fail++; $display("FAIL sat_handshakes: got %0d want 6", hs); end
        n_checks++; if (s_counts !== 20'h00003) begin n_fail++; $display("FAIL sat_counts: got %h want 00003", s_counts); end
    endtask

    task automatic test_timeout();
        s_steps = 8'd2; s_ready = 1'b1; s_res = 10'h3FF; s_vld = 1'b0;
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        repeat (3) @(posedge clk);
        #1 s_vld = 1'b1;
        @(posedge clk); #1 s_vld = 1'b0;
        repeat (8) @(posedge clk);
        #1 s_start = 1'b1; s_steps = 8'd0;
        @(posedge clk); #1 s_start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        n_checks++; if ({s_busy, s_err, s_done} !== 3'b100) begin n_fail++; $display("FAIL timeout_before: busy/err/done got %b want 100", {s_busy, s_err, s_done}); end
        @(posedge clk);
        @(negedge clk);
        n_checks++; if ({s_busy, s_err, s_done} !== 3'b011) begin n_fail++; $display("FAIL timeout_edge: busy/err/done got %b want 011", {s_busy, s_err, s_done}); end
        n_checks++; if (s_counts !== 20'h55555) begin n_fail++; $display("FAIL timeout_partial_counts: got %h want 55555", s_counts); end
        @(posedge clk); #1 s_clear = 1'b1;
        @(posedge clk); #1 s_clear = 1'b0;
        @(negedge clk);
        n_checks++; if ({s_busy, s_err, s_done} !== 3'b000) begin n_fail++; $display("FAIL timeout_clear: busy/err/done got %b want 000", {s_busy, s_err, s_done}); end
    endtask

    task automatic test_reset_mid_wait();
        s_spikes = {32'h0000_00FF, 32'hDEAD_BEEF}; s_steps = 8'd1; s_ready = 1'b1; s_res = 10'h3FF;
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if ({s_busy, s_valid, s_data} !== {2'b10, 40'hFF_DEAD_BEEF}) begin n_fail++; $display("FAIL pre_reset_wait: busy/valid/data got %b%b/%h want 10/ffdeadbeef", s_busy, s_valid, s_data); end
        @(posedge clk); #1 rst = 1'b1; s_vld = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 s_vld = 1'b0;
        @(negedge clk);
        n_checks++; if ({s_valid, s_busy, s_done, s_err} !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_flags: got %b want 0000", {s_valid, s_busy, s_done, s_err}); end
        n_checks++; if (s_data !== 40'd0) begin n_fail++; $display("FAIL mid_reset_data: got %h want 0", s_data); end
        n_checks++; if (s_counts !== 20'd0) begin n_fail++; $display("FAIL mid_reset_counts: got %h want 0", s_counts); end
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_frame_load();
        test_ready_stall();
        test_saturate();
        test_timeout();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
